// File: rtl/bus_stall_bridge_pkg.sv
// rtl/bus_stall_bridge_pkg.sv - shared types and constants for the bus stall bridge
//
// Purpose : bridge FSM state encoding, default timeout read data and
//           statistics counter width.
// Ports   : none (package).
package bus_stall_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;
    localparam int          STAT_WIDTH         = 16;

endpackage

// File: rtl/bus_stall_bridge_if.sv
// rtl/bus_stall_bridge_if.sv - CPU and per-channel signal bundle of the bus stall bridge
//
// Purpose : groups the CPU access port, the per-channel request/response
//           ports and the error flag into one interface.
// Modports: slave  - the bridge (receives CPU accesses, drives channels)
//           master - the environment (CPU and peripherals)
// Option  : BUS_STALL_BRIDGE_STATS_EN adds stat_timeouts_o and
//           stat_max_latency_o.
interface bus_stall_bridge_if #(
    parameter int NumChannels = 4,
    parameter int AddrWidth   = 16,
    parameter int DataWidth   = 32
);
    logic                             cpu_valid_i;
    logic                             cpu_we_i;
    logic [AddrWidth-1:0]             cpu_address_i;
    logic [DataWidth-1:0]             cpu_data_i;
    logic [DataWidth-1:0]             cpu_data_o;
    logic                             cpu_halt_o;
    logic [NumChannels-1:0]           ch_req_valid_o;
    logic [NumChannels-1:0]           ch_req_ready_i;
    logic                             ch_we_o;
    logic [AddrWidth-1:0]             ch_address_o;
    logic [DataWidth-1:0]             ch_data_o;
    logic [NumChannels-1:0]           ch_resp_valid_i;
    logic [NumChannels*DataWidth-1:0] ch_resp_data_i;
    logic                             err_o;
    logic                             err_clear_i;
`ifdef BUS_STALL_BRIDGE_STATS_EN
    logic [15:0]                      stat_timeouts_o;
    logic [15:0]                      stat_max_latency_o;
`endif

    modport slave (
        input  cpu_valid_i, cpu_we_i, cpu_address_i, cpu_data_i,
        input  ch_req_ready_i, ch_resp_valid_i, ch_resp_data_i, err_clear_i,
        output cpu_data_o, cpu_halt_o, ch_req_valid_o, ch_we_o,
        output ch_address_o, ch_data_o, err_o
`ifdef BUS_STALL_BRIDGE_STATS_EN
        , output stat_timeouts_o, stat_max_latency_o
`endif
    );

    modport master (
        output cpu_valid_i, cpu_we_i, cpu_address_i, cpu_data_i,
        output ch_req_ready_i, ch_resp_valid_i, ch_resp_data_i, err_clear_i,
        input  cpu_data_o, cpu_halt_o, ch_req_valid_o, ch_we_o,
        input  ch_address_o, ch_data_o, err_o
`ifdef BUS_STALL_BRIDGE_STATS_EN
        , input stat_timeouts_o, stat_max_latency_o
`endif
    );

endinterface

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational priority address window decoder
//
// Purpose : flags which of NumChannels inclusive address windows contains
//           the address; on overlap the lowest channel index wins.
// Ports   : address   in  access address
//           win_start in  packed window starts (slice k = channel k)
//           win_end   in  packed window ends   (slice k = channel k)
//           hit       out address falls in some window
//           sel       out one-hot winning channel (0 on miss)
module bus_addr_decode #(
    parameter int NumChannels = 4,
    parameter int AddrWidth   = 16
) (
    input  logic [AddrWidth-1:0]             address,
    input  logic [NumChannels*AddrWidth-1:0] win_start,
    input  logic [NumChannels*AddrWidth-1:0] win_end,
    output logic                             hit,
    output logic [NumChannels-1:0]           sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < NumChannels; k++) begin
            if (!hit &&
                address >= win_start[k*AddrWidth +: AddrWidth] &&
                address <= win_end[k*AddrWidth +: AddrWidth]) begin
                hit    = 1'b1;
                sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_stall_bridge.sv
// rtl/bus_stall_bridge.sv - halting CPU-to-peripheral bridge with per-channel handshake and timeout
//
// Purpose : decodes a CPU strobe to one of NumChannels windows, issues it on
//           that channel's valid/ready port, halts the CPU until the write is
//           accepted or read data returns, or returns ErrorData and sets the
//           sticky err_o when TimeoutCycles REQ+WAIT cycles pass.
// Ports   : clk_i   in  system clock
//           reset_i in  asynchronous active-high reset
//           bus     slave modport of bus_stall_bridge_if (CPU side, channel
//                   side, err_o / err_clear_i)
// Option  : BUS_STALL_BRIDGE_STATS_EN adds timeout and max latency counters.
module bus_stall_bridge
    import bus_stall_bridge_pkg::*;
#(
    parameter int                               NumChannels   = 4,
    parameter int                               AddrWidth     = 16,
    parameter int                               DataWidth     = 32,
    parameter logic [NumChannels*AddrWidth-1:0] ChStartAddr   = '0,
    parameter logic [NumChannels*AddrWidth-1:0] ChEndAddr     = '0,
    parameter int                               TimeoutCycles = 255,
    parameter logic [31:0]                      ErrorData     = DEFAULT_ERROR_DATA
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bus_stall_bridge_if.slave bus
);

    localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    bridge_state_t          state;
    logic [IdxW-1:0]        sel_q;
    logic [CntW-1:0]        cnt_q;
    logic [NumChannels-1:0] req_valid_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   err_q;

    logic                   any_hit;
    logic [NumChannels-1:0] hit_onehot;
    logic [IdxW-1:0]        hit_idx;
    logic                   can_accept;
    logic                   accept;
    logic                   busy;
    logic                   req_done;
    logic                   resp_done;
    logic                   timeout_fire;

    bus_addr_decode #(
        .NumChannels (NumChannels),
        .AddrWidth   (AddrWidth)
    ) u_decode (
        .address   (bus.cpu_address_i),
        .win_start (ChStartAddr),
        .win_end   (ChEndAddr),
        .hit       (any_hit),
        .sel       (hit_onehot)
    );

    always_comb begin
        hit_idx = '0;
        for (int k = 0; k < NumChannels; k++) begin
            if (hit_onehot[k]) hit_idx = IdxW'(k);
        end
    end

    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);
    assign busy       = (state == ST_REQ) || (state == ST_WAIT);
    assign accept     = bus.cpu_valid_i && any_hit && can_accept;
    assign req_done   = (state == ST_REQ) && bus.ch_req_ready_i[sel_q];
    assign resp_done  = (state == ST_WAIT) && bus.ch_resp_valid_i[sel_q];
    // A completing handshake/response in the last allowed cycle beats the timeout.
    assign timeout_fire = (TimeoutCycles != 0) && busy &&
                          (cnt_q == CntW'(TimeoutCycles - 1)) &&
                          !req_done && !resp_done;

    // Halt is combinational in the strobe cycle so the CPU stalls immediately.
    assign bus.cpu_halt_o = !reset_i && (accept || busy);

    assign bus.ch_req_valid_o = req_valid_q;
    assign bus.ch_we_o        = we_q;
    assign bus.ch_address_o   = addr_q;
    assign bus.ch_data_o      = wdata_q;
    assign bus.cpu_data_o     = rdata_q;
    assign bus.err_o          = err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            req_valid_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (bus.err_clear_i) err_q <= 1'b0;
            if (busy) cnt_q <= cnt_q + 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        we_q        <= bus.cpu_we_i;
                        addr_q      <= bus.cpu_address_i;
                        wdata_q     <= bus.cpu_data_i;
                        sel_q       <= hit_idx;
                        cnt_q       <= '0;
                        req_valid_q <= hit_onehot;
                        state       <= ST_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (req_done) begin
                        req_valid_q <= '0;
                        state       <= we_q ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_done) begin
                        rdata_q <= bus.ch_resp_data_i[sel_q*DataWidth +: DataWidth];
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (timeout_fire) begin
                req_valid_q <= '0;
                if (!we_q) rdata_q <= DataWidth'(ErrorData);
                err_q <= 1'b1;
                state <= ST_DONE;
            end
        end
    end

`ifdef BUS_STALL_BRIDGE_STATS_EN
    logic [STAT_WIDTH-1:0] stat_to_q;
    logic [STAT_WIDTH-1:0] stat_max_q;
    logic [STAT_WIDTH-1:0] lat_q;
    logic [STAT_WIDTH-1:0] lat_total;
    logic                  finishing;

    // Latency counts the REQ+WAIT cycles, including the finishing one.
    assign lat_total = (&lat_q) ? lat_q : lat_q + 1'b1;
    assign finishing = (req_done && we_q) || resp_done || timeout_fire;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_to_q  <= '0;
            stat_max_q <= '0;
            lat_q      <= '0;
        end else begin
            if (bus.err_clear_i) begin
                stat_to_q  <= '0;
                stat_max_q <= '0;
            end
            if (accept) lat_q <= '0;
            else if (busy) lat_q <= lat_total;
            if (timeout_fire && !(&stat_to_q)) stat_to_q <= stat_to_q + 1'b1;
            if (finishing && (lat_total > stat_max_q || bus.err_clear_i))
                stat_max_q <= lat_total;
        end
    end

    assign bus.stat_timeouts_o    = stat_to_q;
    assign bus.stat_max_latency_o = stat_max_q;
`endif

endmodule

// File: tb/tb_bus_stall_bridge.sv
// tb/tb_bus_stall_bridge.sv - directed self-checking bench for bus_stall_bridge
module tb_bus_stall_bridge;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk_i = ~clk_i;

    bus_stall_bridge_if #(.NumChannels(2), .AddrWidth(16), .DataWidth(32)) bus ();

    bus_stall_bridge #(
        .NumChannels   (2),
        .AddrWidth     (16),
        .DataWidth     (32),
        .ChStartAddr   ({16'hA000, 16'h9000}),
        .ChEndAddr     ({16'hA0FF, 16'h900F}),
        .TimeoutCycles (8),
        .ErrorData     (32'hDEAD_BEEF)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic        exp_halt;
        logic [1:0]  exp_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic we, input logic [15:0] addr, input logic [31:0] data);
        bus.cpu_valid_i   = 1'b1;
        bus.cpu_we_i      = we;
        bus.cpu_address_i = addr;
        bus.cpu_data_i    = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=%0t required=<100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h9000, 1'b1, 2'b01};
        vecs[1] = '{16'h900F, 1'b1, 2'b01};
        vecs[2] = '{16'h9010, 1'b0, 2'b00};
        vecs[3] = '{16'h8FFF, 1'b0, 2'b00};
        vecs[4] = '{16'hA000, 1'b1, 2'b10};
        vecs[5] = '{16'hA0FF, 1'b1, 2'b10};
        vecs[6] = '{16'hA100, 1'b0, 2'b00};
        vecs[7] = '{16'hB000, 1'b0, 2'b00};

        bus.cpu_valid_i     = 1'b0;
        bus.cpu_we_i        = 1'b0;
        bus.cpu_address_i   = '0;
        bus.cpu_data_i      = '0;
        bus.ch_req_ready_i  = '0;
        bus.ch_resp_valid_i = '0;
        bus.ch_resp_data_i  = '0;
        bus.err_clear_i     = 1'b0;

        // Reset state, halt masked even with a hitting strobe
        tick();
        strobe(1'b1, 16'h9000, 32'h0);
        #1;
        check("rst_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        check("rst_valid", {30'd0, bus.ch_req_valid_o}, 32'd0);
        check("rst_cpu_data", bus.cpu_data_o, 32'd0);
        check("rst_addr", {16'd0, bus.ch_address_o}, 32'd0);
        check("rst_err", {31'd0, bus.err_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        bus.cpu_valid_i = 1'b0;
        tick();

        // Decode table: posted writes with immediate ready
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, vecs[i].addr, {16'h0, vecs[i].addr});
            #1;
            check($sformatf("dec%0d_halt", i), {31'd0, bus.cpu_halt_o}, {31'd0, vecs[i].exp_halt});
            tick();
            bus.cpu_valid_i = 1'b0;
            check($sformatf("dec%0d_valid", i), {30'd0, bus.ch_req_valid_o}, {30'd0, vecs[i].exp_valid});
            if (vecs[i].exp_halt) begin
                check($sformatf("dec%0d_addr", i), {16'd0, bus.ch_address_o}, {16'd0, vecs[i].addr});
                bus.ch_req_ready_i = 2'b11;
                tick();
                bus.ch_req_ready_i = 2'b00;
                check($sformatf("dec%0d_done_halt", i), {31'd0, bus.cpu_halt_o}, 32'd0);
                tick();
            end else begin
                check($sformatf("dec%0d_miss_halt", i), {31'd0, bus.cpu_halt_o}, 32'd0);
            end
        end
        check("dec_cpu_data", bus.cpu_data_o, 32'd0);

        // Write 0x9004 = 0x1234, ready low for 3 cycles
        strobe(1'b1, 16'h9004, 32'h1234);
        #1;
        check("wr_strobe_halt", {31'd0, bus.cpu_halt_o}, 32'd1);
        tick();
        bus.cpu_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_valid%0d", i), {30'd0, bus.ch_req_valid_o}, 32'd1);
            check($sformatf("wr_halt%0d", i), {31'd0, bus.cpu_halt_o}, 32'd1);
            check($sformatf("wr_data%0d", i), bus.ch_data_o, 32'h1234);
            if (i == 3) bus.ch_req_ready_i = 2'b01;
            tick();
        end
        bus.ch_req_ready_i = 2'b00;
        check("wr_done_valid", {30'd0, bus.ch_req_valid_o}, 32'd0);
        check("wr_done_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        check("wr_err", {31'd0, bus.err_o}, 32'd0);
        check("wr_cpu_data", bus.cpu_data_o, 32'd0);
        tick();

        // Read 0xA010, immediate ready, response 5 cycles after accept
        strobe(1'b0, 16'hA010, 32'h0);
        tick();
        bus.cpu_valid_i    = 1'b0;
        bus.ch_req_ready_i = 2'b10;
        tick();
        bus.ch_req_ready_i = 2'b00;
        bus.ch_resp_data_i = {32'hCAFE_F00D, 32'h1111_1111};
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("rd_wait_halt%0d", i), {31'd0, bus.cpu_halt_o}, 32'd1);
            bus.ch_resp_valid_i = (i == 3) ? 2'b01 : ((i == 5) ? 2'b10 : 2'b00);
            tick();
        end
        bus.ch_resp_valid_i = 2'b00;
        check("rd_data", bus.cpu_data_o, 32'hCAFE_F00D);
        check("rd_done_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        tick();

        // Read 0xA000 with no ready: timeout after 8 cycles; set beats clear
        strobe(1'b0, 16'hA000, 32'h0);
        tick();
        bus.cpu_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_valid%0d", i), {30'd0, bus.ch_req_valid_o}, 32'd2);
            check($sformatf("to_err%0d", i), {31'd0, bus.err_o}, 32'd0);
            bus.err_clear_i = (i == 7);
            tick();
        end
        bus.err_clear_i = 1'b0;
        check("to_valid_drop", {30'd0, bus.ch_req_valid_o}, 32'd0);
        check("to_data", bus.cpu_data_o, 32'hDEAD_BEEF);
        check("to_err_set", {31'd0, bus.err_o}, 32'd1);
        check("to_done_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        tick();
        check("to_err_sticky", {31'd0, bus.err_o}, 32'd1);
        bus.err_clear_i = 1'b1;
        tick();
        bus.err_clear_i = 1'b0;
        check("to_err_clear", {31'd0, bus.err_o}, 32'd0);

        // Read miss 0xB000: nothing happens
        strobe(1'b0, 16'hB000, 32'h0);
        #1;
        check("miss_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        tick();
        bus.cpu_valid_i = 1'b0;
        check("miss_valid", {30'd0, bus.ch_req_valid_o}, 32'd0);
        check("miss_data", bus.cpu_data_o, 32'hDEAD_BEEF);

        // Response in the timeout cycle wins
        strobe(1'b0, 16'hA004, 32'h0);
        tick();
        bus.cpu_valid_i    = 1'b0;
        bus.ch_req_ready_i = 2'b10;
        tick();
        bus.ch_req_ready_i = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        check("race_halt", {31'd0, bus.cpu_halt_o}, 32'd1);
        bus.ch_resp_data_i  = {32'h600D_CAFE, 32'h0};
        bus.ch_resp_valid_i = 2'b10;
        tick();
        bus.ch_resp_valid_i = 2'b00;
        check("race_data", bus.cpu_data_o, 32'h600D_CAFE);
        check("race_err", {31'd0, bus.err_o}, 32'd0);
        check("race_halt_done", {31'd0, bus.cpu_halt_o}, 32'd0);
        tick();

        // Back-to-back: strobe in DONE goes straight to REQ, then reset mid-WAIT
        strobe(1'b1, 16'h9008, 32'h55);
        tick();
        bus.cpu_valid_i    = 1'b0;
        bus.ch_req_ready_i = 2'b01;
        tick();
        bus.ch_req_ready_i = 2'b00;
        strobe(1'b0, 16'hA020, 32'h0);
        #1;
        check("b2b_done_halt", {31'd0, bus.cpu_halt_o}, 32'd1);
        tick();
        bus.cpu_valid_i = 1'b0;
        check("b2b_valid", {30'd0, bus.ch_req_valid_o}, 32'd2);
        check("b2b_addr", {16'd0, bus.ch_address_o}, 32'h0000_A020);
        check("b2b_we", {31'd0, bus.ch_we_o}, 32'd0);
        bus.ch_req_ready_i = 2'b10;
        tick();
        bus.ch_req_ready_i = 2'b00;
        tick();
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        check("mid_rst_data", bus.cpu_data_o, 32'd0);
        check("mid_rst_addr", {16'd0, bus.ch_address_o}, 32'd0);
        check("mid_rst_wdata", bus.ch_data_o, 32'd0);
        tick();
        reset_i = 1'b0;
        bus.ch_resp_data_i  = {32'h1234_5678, 32'h0};
        bus.ch_resp_valid_i = 2'b10;
        tick();
        bus.ch_resp_valid_i = 2'b00;
        check("late_resp_data", bus.cpu_data_o, 32'd0);
        check("late_resp_halt", {31'd0, bus.cpu_halt_o}, 32'd0);
        check("late_resp_valid", {30'd0, bus.ch_req_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
